seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment display driver, successor to the fixed four-digit controller. It time-multiplexes `NUM_DIGITS` hex digits onto one shared cathode bus plus decimal point. It adds per-digit blanking, leading-zero suppression, configurable pin polarity, and tear-free frame-synchronous updates. It sits between the application datapath and the board's display pins.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/seven_seg_decoder.sv | 32 +++
 rtl/seven_seg_scanner.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types, hex segment patterns (active-high, bit 0 = segment a) and dwell-interval helper
// for the seven-segment scanner.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_A = 7'h77;
    localparam seg_t SEG_B = 7'h7C;
    localparam seg_t SEG_C = 7'h39;
    localparam seg_t SEG_D = 7'h5E;
    localparam seg_t SEG_E = 7'h79;
    localparam seg_t SEG_F = 7'h71;

    // Cycles per digit dwell; 64-bit product so large refresh rates cannot overflow.
    function automatic int interval(input int clk_per, input int refr_rate);
        longint prod;
        prod = longint'(clk_per) * longint'(refr_rate);
        return int'(longint'(1000000000) / prod);
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
// Zero latency; no flow control.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_F;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed hex display driver with frame-synchronous staging; all pins registered (1 cycle).
// Free-running, no backpressure. SEVEN_SEG_DIMMING_EN enables brightness-controlled anode duty.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int CLK_PER         = 10,
    parameter int REFR_RATE       = 1000,
    parameter int ANODE_ACT_LOW   = 1,
    parameter int CATHODE_ACT_LOW = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_DIGITS-1:0][3:0] digits,
    input  logic [NUM_DIGITS-1:0]      dp,
    input  logic [NUM_DIGITS-1:0]      blank,
    input  logic                       lz_suppress,
    input  logic                       update,
    input  logic [3:0]                 brightness,
    output logic [6:0]                 cathode,
    output logic                       dp_out,
    output logic [NUM_DIGITS-1:0]      anode,
    output logic                       frame_start
);

    localparam int INTERVAL = interval(CLK_PER, REFR_RATE);
    localparam int DW = $clog2(INTERVAL);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(INTERVAL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic AN_LVL = (ANODE_ACT_LOW != 0);
    localparam logic CA_LVL = (CATHODE_ACT_LOW != 0);

    logic [DW-1:0] dwell;
    logic [IW-1:0] idx;
    logic          frame_end;

    logic [NUM_DIGITS-1:0][3:0] stg_digits, act_digits;
    logic [NUM_DIGITS-1:0]      stg_dp, act_dp, stg_blank, act_blank;
    logic                       stg_lz, act_lz, pending;

    assign frame_end = (dwell == DWELL_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
            idx   <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // An update landing on the boundary cycle bypasses staging so it shows in the frame about to start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_blank  <= '0;
            stg_lz     <= 1'b0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_lz     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (update) begin
                stg_digits <= digits;
                stg_dp     <= dp;
                stg_blank  <= blank;
                stg_lz     <= lz_suppress;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (update) begin
                    act_digits <= digits;
                    act_dp     <= dp;
                    act_blank  <= blank;
                    act_lz     <= lz_suppress;
                end else if (pending) begin
                    act_digits <= stg_digits;
                    act_dp     <= stg_dp;
                    act_blank  <= stg_blank;
                    act_lz     <= stg_lz;
                end
            end else if (update) begin
                pending <= 1'b1;
            end
        end
    end

    logic [NUM_DIGITS-1:0] lead;
    logic                  zero_run;

    always_comb begin
        zero_run = 1'b1;
        lead     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (act_digits[i] == 4'h0) & ~act_blank[i];
            if (i != 0) lead[i] = act_lz & zero_run;
        end
    end

    logic [6:0] seg;

    seven_seg_decoder u_dec (
        .nibble (act_digits[idx]),
        .seg    (seg)
    );

    logic lit;

`ifdef SEVEN_SEG_DIMMING_EN
    logic [DW:0] thr_q, thr_now, thr_eff;
    int          t_calc;

    always_comb begin
        t_calc  = ((int'(brightness) + 1) * INTERVAL) >>> 4;
        thr_now = (DW + 1)'(t_calc);
        thr_eff = (dwell == '0) ? thr_now : thr_q;
        lit     = ({1'b0, dwell} < thr_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            thr_q <= '0;
        else if (dwell == '0)
            thr_q <= thr_now;
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign lit = 1'b1;
`endif

    logic [NUM_DIGITS-1:0] sel;
    logic                  seg_on, dp_on;

    always_comb begin
        sel    = NUM_DIGITS'(1) << idx;
        seg_on = lit & ~act_blank[idx] & ~lead[idx];
        dp_on  = lit & ~act_blank[idx] & act_dp[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode       <= {NUM_DIGITS{AN_LVL}};
            cathode     <= {7{CA_LVL}};
            dp_out      <= CA_LVL;
            frame_start <= 1'b0;
        end else begin
            anode       <= (sel & {NUM_DIGITS{lit}}) ^ {NUM_DIGITS{AN_LVL}};
            cathode     <= (seg_on ? seg : 7'h00) ^ {7{CA_LVL}};
            dp_out      <= dp_on ^ CA_LVL;
            frame_start <= (dwell == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench: INTERVAL=10, active-low pins; a 4-digit and a 3-digit scanner share clock and reset.
module tb_seven_seg_scanner;

    logic            clk;
    logic            rst_n;
    logic [3:0][3:0] digits;
    logic [3:0]      dp, blank;
    logic            lz_suppress, update;
    logic [3:0]      brightness;
    logic [6:0]      cathode;
    logic            dp_out;
    logic [3:0]      anode;
    logic            frame_start;

    logic [2:0][3:0] digits3;
    logic [2:0]      dp3, blank3;
    logic            lz3, update3;
    logic [6:0]      cathode3;
    logic            dp_out3;
    logic [2:0]      anode3;
    logic            frame_start3;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    int lit_cnt = 0;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .CLK_PER(10), .REFR_RATE(10_000_000),
        .ANODE_ACT_LOW(1), .CATHODE_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank),
        .lz_suppress(lz_suppress), .update(update), .brightness(brightness),
        .cathode(cathode), .dp_out(dp_out), .anode(anode), .frame_start(frame_start)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(3), .CLK_PER(10), .REFR_RATE(10_000_000),
        .ANODE_ACT_LOW(1), .CATHODE_ACT_LOW(1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .digits(digits3), .dp(dp3), .blank(blank3),
        .lz_suppress(lz3), .update(update3), .brightness(brightness),
        .cathode(cathode3), .dp_out(dp_out3), .anode(anode3), .frame_start(frame_start3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge k drives pins from state k-1: digit ((k-1)/10)%4, dwell (k-1)%10.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic run_to(input int k);
        while (edge_cnt < k) tick();
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        digits = '0; dp = '0; blank = '0; lz_suppress = 1'b0; update = 1'b0;
        brightness = 4'hF;
        digits3 = '0; dp3 = '0; blank3 = '0; lz3 = 1'b0; update3 = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check_vec("rst_anode", anode, 4'hF);
        check_vec("rst_cathode", cathode, 7'h7F);
        check_vec("rst_dp", dp_out, 1'b1);
        check_vec("rst_fs", frame_start, 1'b0);
        check_vec("rst_anode3", anode3, 3'h7);

        #24;
        rst_n = 1'b1;
        digits = {4'h4, 4'h3, 4'h2, 4'h1};
        pulse_update();
        check_vec("first_fs", frame_start, 1'b1);
        check_vec("first_anode", anode, 4'hE);
        check_vec("first_cath_zero", cathode, 7'h40);
        check_vec("first_dp", dp_out, 1'b1);
        run_to(2);  check_vec("fs_low", frame_start, 1'b0);
        run_to(41); check_vec("d0_anode", anode, 4'hE);
        check_vec("d0_cath_1", cathode, 7'h79);
        check_vec("f1_fs", frame_start, 1'b1);
        run_to(42); check_vec("f1_fs_low", frame_start, 1'b0);
        run_to(50); check_vec("d0_dwell_end", anode, 4'hE);
        run_to(51); check_vec("d1_anode", anode, 4'hD);
        check_vec("d1_cath_2", cathode, 7'h24);
        run_to(61); check_vec("d2_anode", anode, 4'hB);
        check_vec("d2_cath_3", cathode, 7'h30);
        run_to(71); check_vec("d3_anode", anode, 4'h7);
        check_vec("d3_cath_4", cathode, 7'h19);
        run_to(81); check_vec("f2_fs", frame_start, 1'b1);

        run_to(85);
        digits = {4'h9, 4'h8, 4'h7, 4'h6};
        pulse_update();
        run_to(96);  check_vec("mid_hold_old", cathode, 7'h24);
        run_to(121); check_vec("mid_new_d0", cathode, 7'h02);
        run_to(131); check_vec("mid_new_d1", cathode, 7'h78);
        run_to(151); check_vec("mid_new_d3", cathode, 7'h10);

        run_to(159);
        digits = {4'hA, 4'hB, 4'hC, 4'hD};
        pulse_update();
        run_to(161); check_vec("bnd_d0", cathode, 7'h21);
        check_vec("bnd_anode", anode, 4'hE);
        run_to(171); check_vec("bnd_d1", cathode, 7'h46);

        run_to(175);
        digits = {4'h0, 4'h0, 4'h5, 4'h0};
        dp = 4'b1000;
        lz_suppress = 1'b1;
        pulse_update();
        run_to(201); check_vec("lz_d0", cathode, 7'h40);
        check_vec("lz_d0_dp", dp_out, 1'b1);
        run_to(211); check_vec("lz_d1", cathode, 7'h12);
        run_to(221); check_vec("lz_d2_supp", cathode, 7'h7F);
        run_to(231); check_vec("lz_d3_supp", cathode, 7'h7F);
        check_vec("lz_d3_dp", dp_out, 1'b0);
        check_vec("lz_d3_anode", anode, 4'h7);

        run_to(235);
        digits = {4'h4, 4'h3, 4'h2, 4'h1};
        dp = 4'b0010;
        blank = 4'b0010;
        lz_suppress = 1'b0;
        pulse_update();
        run_to(241); check_vec("blk_d0", cathode, 7'h79);
        run_to(251); check_vec("blk_anode", anode, 4'hD);
        check_vec("blk_cath", cathode, 7'h7F);
        check_vec("blk_dp", dp_out, 1'b1);
        run_to(261); check_vec("blk_d2", cathode, 7'h30);

        run_to(265);
        digits = {4'hF, 4'hF, 4'hF, 4'hF};
        dp = '0;
        blank = '0;
        pulse_update();
        #2 rst_n = 1'b0;
        #1;
        check_vec("midrst_anode", anode, 4'hF);
        check_vec("midrst_cath", cathode, 7'h7F);
        check_vec("midrst_dp", dp_out, 1'b1);
        check_vec("midrst_fs", frame_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_cnt = 0;

        run_to(1);  check_vec("n3_fs0", frame_start3, 1'b1);
        check_vec("n3_idx0", anode3, 3'h6);
        run_to(21); check_vec("n3_idx2", anode3, 3'h3);
        run_to(30); check_vec("n3_fs_low", frame_start3, 1'b0);
        run_to(31); check_vec("n3_fs30", frame_start3, 1'b1);
        check_vec("n3_wrap0", anode3, 3'h6);
        run_to(41); check_vec("discarded_pending", cathode, 7'h40);

`ifdef SEVEN_SEG_DIMMING_EN
        run_to(45);
        brightness = 4'h7;
        run_to(50);
        lit_cnt = 0;
        while (edge_cnt < 90) begin
            tick();
            if (anode != 4'hF) lit_cnt++;
            if (edge_cnt == 58) begin
                check_vec("dim_anode_off", anode, 4'hF);
                check_vec("dim_cath_off", cathode, 7'h7F);
            end
        end
        check_vec("dim_lit_cycles", lit_cnt, 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
